// File: rtl/text_render_pkg.sv
//----------------------------------------------------------------------------
// Module  : text_render_pkg
// Brief   : Shared palette, font-size codes and pipeline depth for the text
//           pixel render stage.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package text_render_pkg;

  localparam logic [11:0] PALETTE [0:15] = '{
    12'h000, 12'hFFF, 12'h0F0, 12'hF00,
    12'h00F, 12'h0FF, 12'hF0F, 12'h888,
    12'hF80, 12'h08F, 12'h8F0, 12'hF08,
    12'h444, 12'hCCC, 12'h800, 12'hFF0
  };

  localparam logic [1:0] FS_X1 = 2'd1;
  localparam logic [1:0] FS_X2 = 2'd2;

  localparam int RENDER_LAT = 3;

  // Unsupported size codes fall back to the native cell.
  function automatic logic [2:0] glyph_col(input logic [3:0] px, input logic [1:0] fs);
    glyph_col = (fs == FS_X2) ? px[3:1] : px[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_frame_counter.sv
//----------------------------------------------------------------------------
// Module  : blink_frame_counter
// Brief   : Counts falling edges of an active-low vsync; wraps at 2^WIDTH.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module blink_frame_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  output logic [WIDTH-1:0] count
);

  logic             r_vs_prev;
  logic [WIDTH-1:0] r_count;

  // Previous value resets high so the idle-high sync after reset never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_prev <= 1'b1;
      r_count   <= '0;
    end else begin
      r_vs_prev <= vsync;
      if (r_vs_prev && !vsync)
        r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/text_pixel_render.sv
//----------------------------------------------------------------------------
// Module  : text_pixel_render
// Brief   : Glyph bit select, palette lookup and sync alignment (3-clock pipe).
//           Optional blink of palette index 15 under macro TEXT_BLINK_EN.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module text_pixel_render
  import text_render_pkg::*;
#(
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixelx,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        dp,
  input  logic [3:0]  color_addr,
  input  logic [1:0]  font_size,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync
);

  logic [3:0]  r_px_a, r_px_b;
  logic        r_von_a, r_von_b;
  logic        r_hs_a, r_hs_b, r_hs_c;
  logic        r_vs_a, r_vs_b, r_vs_c;
  logic        r_dp_b;
  logic [3:0]  r_ca_b;
  logic [1:0]  r_fs_b;
  logic [11:0] r_rgb;

  logic [2:0]  w_col;
  logic        w_glyph;
  logic        w_blink;
  logic [11:0] w_rgb;
  logic        w_unused;

  assign w_unused = ^{pixelx[9:4], BLINK_LOG2[0]};

  // Syncs idle high in reset so the connector never sees a spurious pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px_a  <= '0;
      r_von_a <= 1'b0;
      r_hs_a  <= 1'b1;
      r_vs_a  <= 1'b1;
      r_px_b  <= '0;
      r_von_b <= 1'b0;
      r_hs_b  <= 1'b1;
      r_vs_b  <= 1'b1;
      r_dp_b  <= 1'b0;
      r_ca_b  <= '0;
      r_fs_b  <= '0;
      r_rgb   <= 12'h000;
      r_hs_c  <= 1'b1;
      r_vs_c  <= 1'b1;
    end else begin
      r_px_a  <= pixelx[3:0];
      r_von_a <= video_on;
      r_hs_a  <= hsync_in;
      r_vs_a  <= vsync_in;
      r_px_b  <= r_px_a;
      r_von_b <= r_von_a;
      r_hs_b  <= r_hs_a;
      r_vs_b  <= r_vs_a;
      r_dp_b  <= dp;
      r_ca_b  <= color_addr;
      r_fs_b  <= font_size;
      r_rgb   <= w_rgb;
      r_hs_c  <= r_hs_b;
      r_vs_c  <= r_vs_b;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [BLINK_LOG2-1:0] w_frame;

  blink_frame_counter #(
    .WIDTH (BLINK_LOG2)
  ) u_blink_frame_counter (
    .clk   (clk),
    .reset (reset),
    .vsync (r_vs_b),
    .count (w_frame)
  );

  assign w_blink = w_frame[BLINK_LOG2-1];
`else
  assign w_blink = 1'b0;
`endif

  always_comb begin
    w_col   = glyph_col(r_px_b, r_fs_b);
    w_glyph = rom_data[3'd7 - w_col];
    w_rgb   = BG_RGB;
    if (!r_von_b)
      w_rgb = 12'h000;
    else if (r_dp_b && w_glyph)
      w_rgb = (r_ca_b == 4'hF && w_blink) ? BG_RGB : PALETTE[r_ca_b];
  end

  assign rgb   = r_rgb;
  assign hsync = r_hs_c;
  assign vsync = r_vs_c;

endmodule

`default_nettype wire

// File: tb/tb_text_pixel_render.sv
//----------------------------------------------------------------------------
// Module  : tb_text_pixel_render
// Brief   : Self-checking bench: directed table, blink frames, mid-frame
//           reset and randomized pixels against a behavioural model.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_text_pixel_render;

  localparam logic [11:0] BG = 12'h123;
  localparam int          BL = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixelx = '0;
  logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, dp = 1'b0;
  logic [3:0]  color_addr = '0;
  logic [1:0]  font_size = '0;
  logic [7:0]  rom_data = '0;
  logic [11:0] rgb;
  logic        hsync, vsync;

  text_pixel_render #(.BG_RGB(BG), .BLINK_LOG2(BL)) dut (
    .clk(clk), .reset(reset), .pixelx(pixelx), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dp(dp), .color_addr(color_addr),
    .font_size(font_size), .rom_data(rom_data), .rgb(rgb), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] px; logic von; logic hs; logic vs;
    logic dp; logic [3:0] ca; logic [1:0] fs; logic [7:0] rom;
  } pix_t;

  typedef struct { logic [11:0] rgb; logic hs; logic vs; string nm; } exp_t;
  typedef struct { pix_t p; logic [11:0] exp; string nm; } vec_t;

  logic [11:0] pal [16];
  exp_t q[$];
  pix_t h1, h2;
  int   frames = 0;
  logic prev_vs = 1'b1;
  int   total = 0, bad = 0;

  function automatic pix_t mk(int px, bit von, bit hs, bit vs, bit d, int ca, int fs, int rom);
    pix_t p;
    p.px = 10'(px); p.von = von; p.hs = hs; p.vs = vs;
    p.dp = d; p.ca = 4'(ca); p.fs = 2'(fs); p.rom = 8'(rom);
    return p;
  endfunction

  function automatic logic [11:0] model(pix_t p);
    int  col, pxl, fr;
    bit  g, blink;
    pxl = int'(p.px) % 16;
    col = (p.fs == 2) ? pxl / 2 : pxl % 8;
    g   = ((int'(p.rom) >> (7 - col)) & 1) == 1;
    fr  = frames % (1 << BL);
`ifdef TEXT_BLINK_EN
    blink = (fr >= (1 << (BL - 1)));
`else
    blink = 1'b0;
`endif
    if (!p.von) return 12'h000;
    if (p.dp && g) return (p.ca == 15 && blink) ? BG : pal[p.ca];
    return BG;
  endfunction

  task automatic check(string nm, logic [11:0] act, logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drives one pixel with upstream skew and checks the output that emerges.
  task automatic step(pix_t p, bit rst_now, bit use_exp, logic [11:0] exp_rgb, string nm);
    exp_t e;
    pixelx = p.px; video_on = p.von; hsync_in = p.hs; vsync_in = p.vs;
    dp = h1.dp; color_addr = h1.ca; font_size = h1.fs; rom_data = h2.rom;
    reset = rst_now;
    h2 = h1; h1 = p;
    if (rst_now) begin
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back('{12'h000, 1'b1, 1'b1, "reset"});
      frames = 0; prev_vs = 1'b1;
    end else begin
      e.rgb = use_exp ? exp_rgb : model(p);
      e.hs = p.hs; e.vs = p.vs; e.nm = nm;
      q.push_back(e);
      if (prev_vs && !p.vs) frames++;
      prev_vs = p.vs;
    end
    @(posedge clk); #1;
    e = q.pop_front();
    check({e.nm, ".rgb"}, rgb, e.rgb);
    check({e.nm, ".hsync"}, {11'b0, hsync}, {11'b0, e.hs});
    check({e.nm, ".vsync"}, {11'b0, vsync}, {11'b0, e.vs});
  endtask

  function automatic pix_t rnd();
    return mk($urandom_range(0, 1023), $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(0, 255));
  endfunction

  vec_t tbl[$];
  pix_t idle;

  initial begin
    pal = '{12'h000, 12'hFFF, 12'h0F0, 12'hF00, 12'h00F, 12'h0FF, 12'hF0F, 12'h888,
            12'hF80, 12'h08F, 12'h8F0, 12'hF08, 12'h444, 12'hCCC, 12'h800, 12'hFF0};
    idle = mk(0, 0, 1, 1, 0, 0, 0, 0);
    h1 = idle; h2 = idle;

    tbl.push_back('{mk(8, 1, 1, 1, 1, 2, 1, 'h80), 12'h0F0, "px8_green"});
    tbl.push_back('{mk(9, 1, 1, 1, 1, 2, 1, 'h80), BG,      "px9_bg"});
    tbl.push_back('{mk(3, 1, 0, 1, 1, 2, 1, 'h10), 12'h0F0, "hs_pulse"});
    tbl.push_back('{mk(5, 0, 1, 1, 1, 3, 1, 'hFF), 12'h000, "blank"});
    tbl.push_back('{mk(2, 1, 1, 1, 1, 5, 2, 'h40), 12'h0FF, "x2_px2"});
    tbl.push_back('{mk(3, 1, 1, 1, 1, 5, 2, 'h40), 12'h0FF, "x2_px3"});
    tbl.push_back('{mk(0, 1, 1, 1, 1, 5, 2, 'h40), BG,      "x2_px0"});
    tbl.push_back('{mk(1, 1, 1, 1, 1, 5, 2, 'h40), BG,      "x2_px1"});
    tbl.push_back('{mk(4, 1, 1, 0, 1, 5, 2, 'h40), BG,      "x2_px4"});
    tbl.push_back('{mk(17, 1, 1, 1, 1, 3, 0, 'h40), 12'hF00, "fs0_as_x1"});
    tbl.push_back('{mk(25, 1, 1, 1, 1, 4, 3, 'h40), 12'h00F, "fs3_as_x1"});
    tbl.push_back('{mk(7, 1, 1, 1, 0, 1, 1, 'hFF), BG,      "no_char"});
    tbl.push_back('{mk(6, 1, 1, 1, 1, 1, 1, 'h00), BG,      "rom_zero"});
    tbl.push_back('{mk(15, 1, 1, 1, 1, 11, 2, 'h01), 12'hF08, "x2_px15"});

    for (int i = 0; i < 3; i++) step(rnd(), 1'b1, 1'b0, 12'h0, "reset");
    for (int i = 0; i < 3; i++) step(rnd(), 1'b0, 1'b0, 12'h0, "post_reset");
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b0, 12'h0, "idle");

    foreach (tbl[i]) step(tbl[i].p, 1'b0, 1'b1, tbl[i].exp, tbl[i].nm);
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b0, 12'h0, "flush");

    // Blink: five pixels per frame, vsync low on the last one.
    step(idle, 1'b1, 1'b0, 12'h0, "reset");
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b0, 12'h0, "idle");
    for (int f = 0; f <= 32; f++) begin
      logic [11:0] want;
`ifdef TEXT_BLINK_EN
      want = (f >= 16 && f < 32) ? BG : 12'hFF0;
`else
      want = 12'hFF0;
`endif
      for (int k = 0; k < 5; k++)
        step(mk(k, 1, 1, k != 4, 1, 15, 1, 'hFF), 1'b0, 1'b1, want, $sformatf("blink_f%0d", f));
    end

    // Mid-frame reset inside a green glyph run.
    for (int k = 0; k < 12; k++)
      step(mk(k, 1, 1, 1, 1, 2, 1, 'hFF), k == 5, 1'b1, 12'h0F0, "glyph_run");
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b0, 12'h0, "flush");

    for (int i = 0; i < 400; i++)
      step(rnd(), $urandom_range(0, 63) == 0, 1'b0, 12'h0, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_pixel_render.md
# text_pixel_render

Final pixel stage of the text overlay datapath. It takes the per-pixel character decision (`dp`, `color_addr`, `font_size`) and the font-ROM row byte returned for the overlay's `rom_addr`. It selects the glyph bit for the current column, maps it through a fixed 16-entry palette, and drives registered RGB plus the sync signals delayed to match. It sits between the overlay/font ROM pair and the VGA connector.

## Interface
Parameters:
- `BG_RGB`, default 12'h000: background colour for glyph-off pixels inside the active area.
- `BLINK_LOG2`, default 5: blink half-period is 2^(BLINK_LOG2-1) frames. Used only when blink is compiled in.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `pixelx`  in  10  current pixel column, cycle n.
- `video_on`  in  1  active-area flag, cycle n.
- `hsync_in`, `vsync_in`  in  1 each  active-low syncs, cycle n.
- `dp`  in  1  character present; registered upstream, valid at n+1.
- `color_addr`  in  4  palette index, valid at n+1.
- `font_size`  in  2  1 = native 8-px cell, 2 = double width; valid at n+1.
- `rom_data`  in  8  font row byte from the synchronous ROM, valid at n+2. Bit 7 is the leftmost pixel.
- `rgb`  out  12  {R[3:0],G[3:0],B[3:0]}, valid at n+3.
- `hsync`, `vsync`  out  1 each  `hsync_in`/`vsync_in` delayed 3 cycles.

## Operation
- Pipeline advances every `clk`; there is no stall.
- Stage A (n→n+1): register `pixelx[3:0]`, `video_on`, `hsync_in`, `vsync_in`.
- Stage B (n+1→n+2): shift the stage-A values one more stage. Register `dp`, `color_addr`, `font_size`.
- Stage C (n+2→n+3), computes the output:
  - Column select `col` = `px[2:0]` when `font_size`==1. `col` = `px[3:1]` when `font_size`==2. Values 0 and 3 are treated as 1.
  - Glyph bit `g` = `rom_data[7-col]`.
  - If `video_on`==0, `rgb`=12'h000.
  - Else if `dp`==1 and `g`==1, `rgb`=`PALETTE[color_addr]`.
  - Otherwise `rgb`=`BG_RGB`.
- `rom_data`==8'h00 (blank character 0) always yields background; no special case is needed.
- Reset values:
  - `rgb`=12'h000.
  - `hsync`=1, `vsync`=1.
  - All pipeline registers cleared, `video_on` pipe = 0.
  - Frame counter = 0.
- Reset mid-frame: outputs are forced to reset values on the next edge. Valid output resumes 3 cycles after `reset` deasserts. No partial glyph is emitted.

## Timing
- Latency: 3 clocks from `pixelx`/`video_on`/sync to `rgb`/`hsync`/`vsync`. The sync-to-RGB skew is 0.
- `dp`/`color_addr`/`font_size` are sampled exactly 1 clock after their `pixelx`. `rom_data` is sampled exactly 2 clocks after its `pixelx`.
- Throughput: 1 pixel per clock. Any pixel-rate decimation is the upstream timing generator's concern.

## Configuration
- Macro `TEXT_BLINK_EN`, defined: blink is compiled in.
  - The frame counter (BLINK_LOG2 bits) increments on each falling edge of the stage-B `vsync` (previous 1, current 0). It wraps to 0.
  - When `color_addr`==4'hF and counter bit [BLINK_LOG2-1]==1, glyph-on pixels render `BG_RGB`.
  - A falling edge during reset does not count.
- Macro not defined: no counter exists, and index 15 renders `PALETTE[15]` steadily.

## Structure
- Shared package `text_render_pkg` holds:
  - `PALETTE[0:15]` (12-bit constants; index 2 = 12'h0F0 clock green, index 15 = 12'hFF0 edit yellow, index 0 = 12'h000).
  - Font-size codes `FS_X1`=2'd1, `FS_X2`=2'd2.
  - Pipeline depth constant `RENDER_LAT`=3.
- One sub-module, `blink_frame_counter`: vsync edge detector plus wrap counter, instantiated only under `TEXT_BLINK_EN`.

## Test plan
- Reset: assert `reset` 3 clocks with toggling inputs → `rgb`=12'h000, `hsync`=`vsync`=1 throughout and for 3 clocks after release.
- Latency/alignment:
  - `pixelx`=8, `video_on`=1 at n; `dp`=1, `color_addr`=2, `font_size`=1 at n+1; `rom_data`=8'h80 at n+2 → `rgb`=12'h0F0 at n+3.
  - Same stimulus with `pixelx`=9 → `BG_RGB`.
  - A single-cycle `hsync_in` low pulse appears on `hsync` exactly 3 clocks later.
- Blanking: `video_on`=0 with `dp`=1, `rom_data`=8'hFF → `rgb`=12'h000.
- Double width: `font_size`=2, `rom_data`=8'h40:
  - `pixelx`=2,3 → palette colour.
  - `pixelx`=0,1,4 → background.
- Blink (`TEXT_BLINK_EN`, `BLINK_LOG2`=5): `color_addr`=15, glyph on, 32 vsync falling edges.
  - Frames 0–15 → 12'hFF0.
  - Frames 16–31 → `BG_RGB`.
  - Frame 32 → 12'hFF0 (wrap).
  - Macro undefined → 12'hFF0 in all frames.
- Mid-frame reset: assert `reset` for 1 clock during a glyph run → next edge `rgb`=0, then correct pixels from reset release +3.
